// File: rtl/sbox_lookup_server.sv
// sbox_lookup_server: pipelined 4-lane AES S-Box responder for SubBytes column lookups.
// Each accepted column returns four substituted bytes with a done pulse LATENCY (1 or 2)
// cycles later, tagged with its column position inside the 16-byte state.
// Optional feature macro: SBOX_INVERSE_EN adds the inv port and the InvS-Box path.
module sbox_lookup_server #(
  parameter int LATENCY = 1,
  parameter int COLS    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_en,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] addr2,
  input  logic [7:0] addr3,
`ifdef SBOX_INVERSE_EN
  input  logic       inv,
`endif
  output logic [7:0] dout0,
  output logic [7:0] dout1,
  output logic [7:0] dout2,
  output logic [7:0] dout3,
  output logic       done,
  output logic [1:0] col_idx,
  output logic       col_last,
  output logic       busy
);

  localparam logic [1:0] LAST_COL = 2'(COLS - 1);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 by shift-and-add
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (x^2*x^4*...*x^128); maps 0 to 0 naturally
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // Forward S-Box: affine transform of the GF inverse
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

`ifdef SBOX_INVERSE_EN
  // Inverse S-Box: undo the affine transform first, then take the GF inverse
  function automatic logic [7:0] sbox_inv(input logic [7:0] y);
    return gf_inv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
  endfunction
`endif

  logic [1:0]  col_cnt;
  logic        f_valid;
  logic [31:0] f_addr;
  logic [1:0]  f_col;
  logic [31:0] f_result;
`ifdef SBOX_INVERSE_EN
  logic        f_inv;
`endif

  // Column numbering advances once per accepted request and wraps at the end of the state
  always_ff @(posedge clk) begin
    if (rst)        col_cnt <= 2'd0;
    else if (rd_en) col_cnt <= (col_cnt == LAST_COL) ? 2'd0 : col_cnt + 2'd1;
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      logic        s_valid;
      logic [31:0] s_addr;
      logic [1:0]  s_col;
`ifdef SBOX_INVERSE_EN
      logic        s_inv;
`endif

      // Input stage register: the lookup runs in the following cycle, off the input path
      always_ff @(posedge clk) begin
        if (rst) begin
          s_valid <= 1'b0;
          s_addr  <= 32'h0;
          s_col   <= 2'd0;
`ifdef SBOX_INVERSE_EN
          s_inv   <= 1'b0;
`endif
        end else begin
          s_valid <= rd_en;
          if (rd_en) begin
            s_addr <= {addr3, addr2, addr1, addr0};
            s_col  <= col_cnt;
`ifdef SBOX_INVERSE_EN
            s_inv  <= inv;
`endif
          end
        end
      end

      assign f_valid = s_valid;
      assign f_addr  = s_addr;
      assign f_col   = s_col;
`ifdef SBOX_INVERSE_EN
      assign f_inv   = s_inv;
`endif
      assign busy    = s_valid | done;
    end else begin : g_lat1
      assign f_valid = rd_en;
      assign f_addr  = {addr3, addr2, addr1, addr0};
      assign f_col   = col_cnt;
`ifdef SBOX_INVERSE_EN
      assign f_inv   = inv;
`endif
      assign busy    = done;
    end
  endgenerate

  // Four independent byte substitutions, one per lane
  always_comb begin
    f_result = 32'h0;
    for (int k = 0; k < 4; k++) begin
`ifdef SBOX_INVERSE_EN
      f_result[8*k +: 8] = f_inv ? sbox_inv(f_addr[8*k +: 8]) : sbox_fwd(f_addr[8*k +: 8]);
`else
      f_result[8*k +: 8] = sbox_fwd(f_addr[8*k +: 8]);
`endif
    end
  end

  // Output register: data and column tag only update on a valid result, done is a single pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      col_last <= 1'b0;
      col_idx  <= 2'd0;
      dout0    <= 8'h00;
      dout1    <= 8'h00;
      dout2    <= 8'h00;
      dout3    <= 8'h00;
    end else begin
      done     <= f_valid;
      col_last <= f_valid && (f_col == LAST_COL);
      if (f_valid) begin
        col_idx <= f_col;
        dout0   <= f_result[7:0];
        dout1   <= f_result[15:8];
        dout2   <= f_result[23:16];
        dout3   <= f_result[31:24];
      end
    end
  end

endmodule

// File: tb/tb_sbox_lookup_server.sv
// Bench for sbox_lookup_server: one LATENCY=1 and one LATENCY=2 instance share the stimulus
// and are compared against a history-based reference built from GF(2^8) arithmetic.
module tb_sbox_lookup_server;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rd_en;
  logic [7:0] a0, a1, a2, a3;
`ifdef SBOX_INVERSE_EN
  logic       inv;
`endif

  logic [7:0] p0, p1, p2, p3, q0, q1, q2, q3;
  logic       done1, done2, last1, last2, busy1, busy2;
  logic [1:0] col1, col2;

  sbox_lookup_server #(.LATENCY(1), .COLS(4)) u1 (
    .clk(clk), .rst(rst), .rd_en(rd_en),
    .addr0(a0), .addr1(a1), .addr2(a2), .addr3(a3),
`ifdef SBOX_INVERSE_EN
    .inv(inv),
`endif
    .dout0(p0), .dout1(p1), .dout2(p2), .dout3(p3),
    .done(done1), .col_idx(col1), .col_last(last1), .busy(busy1)
  );

  sbox_lookup_server #(.LATENCY(2), .COLS(4)) u2 (
    .clk(clk), .rst(rst), .rd_en(rd_en),
    .addr0(a0), .addr1(a1), .addr2(a2), .addr3(a3),
`ifdef SBOX_INVERSE_EN
    .inv(inv),
`endif
    .dout0(q0), .dout1(q1), .dout2(q2), .dout3(q3),
    .done(done2), .col_idx(col2), .col_last(last2), .busy(busy2)
  );

  logic [31:0] o_dout [2];
  logic        o_done [2];
  logic [1:0]  o_col  [2];
  logic        o_last [2];
  logic        o_busy [2];
  assign o_dout[0] = {p3, p2, p1, p0};
  assign o_dout[1] = {q3, q2, q1, q0};
  assign o_done[0] = done1;
  assign o_done[1] = done2;
  assign o_col[0]  = col1;
  assign o_col[1]  = col2;
  assign o_last[0] = last1;
  assign o_last[1] = last2;
  assign o_busy[0] = busy1;
  assign o_busy[1] = busy2;

  int total = 0;
  int bad   = 0;

  // Reference tables
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  // Request history: one entry per clock step
  bit          hv [4096];
  bit          hr [4096];
  logic [31:0] hd [4096];
  logic [1:0]  hc [4096];
  int          cyc   = 0;
  int          m_col = 0;

  // Expected outputs per instance (index 0: LATENCY=1, index 1: LATENCY=2)
  bit          e_done   [2];
  logic [31:0] e_dout   [2];
  logic [1:0]  e_col    [2];
  bit          e_last   [2];
  bit          e_busy   [2];
  bit          e_colchk [2];

  // Carry-less product followed by polynomial long division by 0x11B
  function automatic int gf_mul_ref(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) == 1) p = p ^ (a << i);
    for (int bit_n = 14; bit_n >= 8; bit_n--)
      if (((p >> bit_n) & 1) == 1) p = p ^ ('h11B << (bit_n - 8));
    return p;
  endfunction

  task automatic build_tables();
    int invx, s, bi;
    for (int x = 0; x < 256; x++) begin
      invx = 0;
      if (x != 0) for (int y = 1; y < 256; y++) if (gf_mul_ref(x, y) == 1) invx = y;
      s = 0;
      for (int i = 0; i < 8; i++) begin
        bi = ((invx >> i) ^ (invx >> ((i + 4) % 8)) ^ (invx >> ((i + 5) % 8)) ^
              (invx >> ((i + 6) % 8)) ^ (invx >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
        s = s | (bi << i);
      end
      fwd_tab[x] = 8'(s);
    end
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
  endtask

  function automatic logic [31:0] ref_lookup(input logic [31:0] ad, input bit iv);
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = iv ? inv_tab[ad[8*k +: 8]] : fwd_tab[ad[8*k +: 8]];
    return r;
  endfunction

  // Drive one cycle of stimulus, record it in the history and derive what each instance should show
  task automatic step(input bit r, input bit en, input logic [31:0] ad, input bit iv);
    bit ive;
    int src;
    bit ok;
    ive = iv;
`ifdef SBOX_INVERSE_EN
    inv = iv;
`else
    ive = 1'b0;
`endif
    rst = r;
    rd_en = en;
    {a3, a2, a1, a0} = ad;
    hr[cyc] = r;
    hv[cyc] = en && !r;
    hd[cyc] = ref_lookup(ad, ive);
    hc[cyc] = 2'(m_col);
    if (r) m_col = 0;
    else if (en) m_col = (m_col + 1) % 4;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      src = cyc - d;
      ok  = (src >= 0) && hv[src];
      for (int k = (src < 0 ? 0 : src); k <= cyc; k++) if (hr[k]) ok = 1'b0;
      if (hr[cyc]) begin
        e_dout[d] = 32'h0;
        e_col[d]  = 2'd0;
      end
      e_last[d] = 1'b0;
      if (ok) begin
        e_dout[d] = hd[src];
        e_col[d]  = hc[src];
        e_last[d] = (hc[src] == 2'd3);
      end
      e_done[d]   = ok;
      e_colchk[d] = ok || hr[cyc];
      e_busy[d]   = ok || (d == 1 && hv[cyc]);
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, $urandom, 1'b0);
    step(1'b1, 1'b1, $urandom, 1'b0);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (o_done[d] !== 1'b0) begin bad++; $display("[TB] FAIL reset_done L%0d got=%0b want=0", d + 1, o_done[d]); end
      total++;
      if (o_dout[d] !== 32'h0) begin bad++; $display("[TB] FAIL reset_dout L%0d got=%h want=00000000", d + 1, o_dout[d]); end
      total++;
      if (o_col[d] !== 2'd0 || o_last[d] !== 1'b0 || o_busy[d] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_ctrl L%0d got col=%0d last=%0b busy=%0b want 0/0/0", d + 1, o_col[d], o_last[d], o_busy[d]);
      end
    end
  endtask

  task automatic test_single();
    int ndone [2];
    ndone = '{0, 0};
    step(1'b1, 1'b0, $urandom, 1'b0);
    step(1'b0, 1'b1, 32'hFF530100, 1'b0);
    for (int c = 0; c < 4; c++) begin
      for (int d = 0; d < 2; d++) begin
        total++;
        if (o_done[d] !== e_done[d]) begin bad++; $display("[TB] FAIL single_done L%0d got=%0b want=%0b", d + 1, o_done[d], e_done[d]); end
        if (o_done[d] === 1'b1) begin
          ndone[d]++;
          total++;
          if (o_dout[d] !== 32'h16ED7C63) begin bad++; $display("[TB] FAIL single_dout L%0d got=%h want=16ed7c63", d + 1, o_dout[d]); end
          total++;
          if (o_col[d] !== 2'd0) begin bad++; $display("[TB] FAIL single_col L%0d got=%0d want=0", d + 1, o_col[d]); end
        end
      end
      step(1'b0, 1'b0, $urandom, 1'b0);
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (ndone[d] !== 1) begin bad++; $display("[TB] FAIL single_pulses L%0d got=%0d want=1", d + 1, ndone[d]); end
    end
  endtask

  task automatic test_back_to_back();
    int n [2];
    n = '{0, 0};
    step(1'b1, 1'b0, $urandom, 1'b0);
    for (int c = 0; c < 8; c++) begin
      step(1'b0, c < 5, $urandom, 1'b0);
      for (int d = 0; d < 2; d++) begin
        total++;
        if (o_done[d] !== (c >= d && c < 5 + d)) begin
          bad++;
          $display("[TB] FAIL b2b_done L%0d cycle=%0d got=%0b want=%0b", d + 1, c, o_done[d], (c >= d && c < 5 + d));
        end
        if (o_done[d] === 1'b1) begin
          total++;
          if (o_col[d] !== 2'(n[d] % 4) || o_last[d] !== (n[d] == 3)) begin
            bad++;
            $display("[TB] FAIL b2b_col L%0d got col=%0d last=%0b want col=%0d last=%0b", d + 1, o_col[d], o_last[d], n[d] % 4, (n[d] == 3));
          end
          total++;
          if (o_dout[d] !== e_dout[d]) begin bad++; $display("[TB] FAIL b2b_dout L%0d got=%h want=%h", d + 1, o_dout[d], e_dout[d]); end
          n[d]++;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (n[d] !== 5) begin bad++; $display("[TB] FAIL b2b_count L%0d got=%0d want=5", d + 1, n[d]); end
    end
  endtask

  task automatic test_gaps();
    step(1'b1, 1'b0, $urandom, 1'b0);
    for (int r = 0; r < 5; r++) begin
      step(1'b0, 1'b1, $urandom, 1'b0);
      for (int g = 0; g < 4; g++) begin
        for (int d = 0; d < 2; d++) begin
          total++;
          if (o_done[d] !== e_done[d] || o_busy[d] !== e_busy[d]) begin
            bad++;
            $display("[TB] FAIL gap_ctrl L%0d got done=%0b busy=%0b want done=%0b busy=%0b", d + 1, o_done[d], o_busy[d], e_done[d], e_busy[d]);
          end
          total++;
          if (o_dout[d] !== e_dout[d]) begin bad++; $display("[TB] FAIL gap_dout L%0d got=%h want=%h", d + 1, o_dout[d], e_dout[d]); end
          if (e_done[d]) begin
            total++;
            if (o_col[d] !== 2'(r % 4)) begin bad++; $display("[TB] FAIL gap_col L%0d got=%0d want=%0d", d + 1, o_col[d], r % 4); end
          end
        end
        if (g < 3) step(1'b0, 1'b0, $urandom, 1'b0);
      end
    end
  endtask

  task automatic test_reset_inflight();
    step(1'b1, 1'b0, $urandom, 1'b0);
    step(1'b0, 1'b1, $urandom, 1'b0);
    step(1'b0, 1'b1, $urandom, 1'b0);
    step(1'b1, 1'b1, $urandom, 1'b0);
    for (int c = 0; c < 2; c++) begin
      for (int d = 0; d < 2; d++) begin
        total++;
        if (o_done[d] !== 1'b0 || o_busy[d] !== 1'b0) begin
          bad++;
          $display("[TB] FAIL flush_ctrl L%0d step=%0d got done=%0b busy=%0b want 0/0", d + 1, c, o_done[d], o_busy[d]);
        end
        total++;
        if (o_dout[d] !== 32'h0 || o_col[d] !== 2'd0) begin
          bad++;
          $display("[TB] FAIL flush_out L%0d got dout=%h col=%0d want 00000000/0", d + 1, o_dout[d], o_col[d]);
        end
      end
      if (c == 0) step(1'b0, 1'b0, $urandom, 1'b0);
    end
    step(1'b0, 1'b1, $urandom, 1'b0);
    step(1'b0, 1'b0, $urandom, 1'b0);
    total++;
    if (o_done[1] !== 1'b1 || o_col[1] !== 2'd0 || o_dout[1] !== e_dout[1]) begin
      bad++;
      $display("[TB] FAIL flush_next got done=%0b col=%0d dout=%h want 1/0/%h", o_done[1], o_col[1], o_dout[1], e_dout[1]);
    end
  endtask

`ifdef SBOX_INVERSE_EN
  task automatic test_inverse();
    step(1'b1, 1'b0, $urandom, 1'b0);
    step(1'b0, 1'b1, 32'h16ED7C63, 1'b1);
    total++;
    if (o_dout[0] !== 32'hFF530100) begin bad++; $display("[TB] FAIL inv_known got=%h want=ff530100", o_dout[0]); end
    for (int c = 0; c < 12; c++) begin
      step(1'b0, c < 10, $urandom, c[0]);
      for (int d = 0; d < 2; d++) begin
        total++;
        if (o_done[d] !== e_done[d] || o_dout[d] !== e_dout[d]) begin
          bad++;
          $display("[TB] FAIL inv_alt L%0d got done=%0b dout=%h want done=%0b dout=%h", d + 1, o_done[d], o_dout[d], e_done[d], e_dout[d]);
        end
      end
    end
  endtask
`endif

  task automatic test_sweep();
    int n [2];
    n = '{0, 0};
    step(1'b1, 1'b0, $urandom, 1'b0);
    for (int i = 0; i < 258; i++) begin
      step(1'b0, i < 256, {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)}, 1'b0);
      for (int d = 0; d < 2; d++) begin
        if (o_done[d] === 1'b1) n[d]++;
        if (e_done[d]) begin
          total++;
          if (o_dout[d] !== e_dout[d]) begin bad++; $display("[TB] FAIL sweep_dout L%0d i=%0d got=%h want=%h", d + 1, i, o_dout[d], e_dout[d]); end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (n[d] !== 256) begin bad++; $display("[TB] FAIL sweep_count L%0d got=%0d want=256", d + 1, n[d]); end
    end
  endtask

  task automatic test_random();
    bit iv;
    step(1'b1, 1'b0, $urandom, 1'b0);
    for (int c = 0; c < 300; c++) begin
      iv = 1'($urandom_range(0, 1));
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom, iv);
      for (int d = 0; d < 2; d++) begin
        total++;
        if (o_done[d] !== e_done[d] || o_busy[d] !== e_busy[d] || o_last[d] !== e_last[d]) begin
          bad++;
          $display("[TB] FAIL rnd_ctrl L%0d c=%0d got done=%0b busy=%0b last=%0b want %0b/%0b/%0b", d + 1, c,
                   o_done[d], o_busy[d], o_last[d], e_done[d], e_busy[d], e_last[d]);
        end
        total++;
        if (o_dout[d] !== e_dout[d]) begin bad++; $display("[TB] FAIL rnd_dout L%0d c=%0d got=%h want=%h", d + 1, c, o_dout[d], e_dout[d]); end
        if (e_colchk[d]) begin
          total++;
          if (o_col[d] !== e_col[d]) begin bad++; $display("[TB] FAIL rnd_col L%0d c=%0d got=%0d want=%0d", d + 1, c, o_col[d], e_col[d]); end
        end
      end
    end
  endtask

  // Test sequence
  initial begin
    build_tables();
    test_reset();
    test_single();
    test_back_to_back();
    test_gaps();
    test_reset_inflight();
`ifdef SBOX_INVERSE_EN
    test_inverse();
`endif
    test_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
